// File: rtl/arb_pkg.sv
// Shared definitions for the two-master AXI read arbiter: FSM encoding and master indices.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision. Purely combinational; the caller registers the result.
module rr_arb2
    import arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);

    // A tie goes to the master that was not served last; a lone requester always wins.
    always_comb begin
        gnt = M_IFU;
        if (req == 2'b11) begin
            gnt = ~last;
        end else if (req[1]) begin
            gnt = M_LSU;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates AR/R channels of a fetch unit (m0) and a load unit (m1) onto one memory
// read port, with a single outstanding read.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | nothing in flight; arbitrate and register the winner
//   ADDR  | winner's address forwarded; wait for s_arvalid && s_arready
//   DATA  | R channel routed to the winner; wait for s_rvalid && s_rready
module axi_rd_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] m0_araddr,
    input  logic             m0_arvalid,
    output logic             m0_arready,
    output logic [WIDTH-1:0] m0_rdata,
    output logic [1:0]       m0_rresp,
    output logic             m0_rvalid,
    input  logic             m0_rready,
    input  logic [WIDTH-1:0] m1_araddr,
    input  logic             m1_arvalid,
    output logic             m1_arready,
    output logic [WIDTH-1:0] m1_rdata,
    output logic [1:0]       m1_rresp,
    output logic             m1_rvalid,
    input  logic             m1_rready,
    output logic [WIDTH-1:0] s_araddr,
    output logic             s_arvalid,
    input  logic             s_arready,
    input  logic [WIDTH-1:0] s_rdata,
    input  logic [1:0]       s_rresp,
    input  logic             s_rvalid,
    output logic             s_rready,
    output logic             busy,
    output logic             grant
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       grant_q;
    logic       last_q;
    logic       rr_gnt;
    logic [1:0] req;
    logic       ar_valid_sel;
    logic       r_ready_sel;
    logic       r_done;

    assign req = {m1_arvalid, m0_arvalid};

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant is latched when leaving IDLE; last-grant is updated only when a read completes,
    // so an aborted transaction does not disturb fairness.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= M_IFU;
            last_q  <= M_LSU;
        end else begin
            if (state_q == IDLE && req != 2'b00) begin
                grant_q <= rr_gnt;
            end
            if (r_done) begin
                last_q <= grant_q;
            end
        end
    end

    // Next state and all channel routing; every output defaults to the idle/quiet value.
    always_comb begin
        state_d      = state_q;
        m0_arready   = 1'b0;
        m1_arready   = 1'b0;
        m0_rvalid    = 1'b0;
        m1_rvalid    = 1'b0;
        m0_rdata     = '0;
        m1_rdata     = '0;
        m0_rresp     = 2'b00;
        m1_rresp     = 2'b00;
        s_araddr     = '0;
        s_arvalid    = 1'b0;
        s_rready     = 1'b0;
        ar_valid_sel = 1'b0;
        r_ready_sel  = 1'b0;
        r_done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = ADDR;
                end
            end

            ADDR: begin
                ar_valid_sel = (grant_q == M_LSU) ? m1_arvalid : m0_arvalid;
                s_araddr     = (grant_q == M_LSU) ? m1_araddr  : m0_araddr;
                s_arvalid    = ar_valid_sel;
                if (grant_q == M_LSU) begin
                    m1_arready = s_arready;
                end else begin
                    m0_arready = s_arready;
                end
                if (ar_valid_sel && s_arready) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                m0_rdata    = s_rdata;
                m1_rdata    = s_rdata;
                m0_rresp    = s_rresp;
                m1_rresp    = s_rresp;
                r_ready_sel = (grant_q == M_LSU) ? m1_rready : m0_rready;
                s_rready    = r_ready_sel;
                if (grant_q == M_LSU) begin
                    m1_rvalid = s_rvalid;
                end else begin
                    m0_rvalid = s_rvalid;
                end
                if (s_rvalid && r_ready_sel) begin
                    r_done  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign grant = grant_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: queued master requests, a memory model with
// programmable wait states, and per-scenario tasks with hand-computed expectations.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [31:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic        busy, grant;

    axi_rd_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // request / response queues fed by the tests
    logic [31:0] m0_q[$];
    logic [31:0] m1_q[$];
    logic [31:0] mem_data_q[$];
    logic [1:0]  mem_resp_q[$];
    int ar_wait = 0;
    int r_wait  = 0;

    // agent state
    int  ar_cnt = 0, r_cnt = 0, rise0 = 0, rise1 = 0;
    bit  r_pend = 0, ar_fire = 0, r_fire = 0, m0_fire = 0, m1_fire = 0;
    bit  ar_hold = 0;
    logic [31:0] ar_hold_addr = '0;

    // logs and monitors
    int          lg_m[$];
    logic [31:0] lg_data[$];
    logic [1:0]  lg_resp[$];
    int          lg_grant[$];
    int          lg_lat[$];
    logic [31:0] lg_addr[$];
    int          gap_q[$];
    int          idle_run = 0;
    bit          seen_busy = 0;
    int          viol_ng = 0, m1_seen = 0, early_r = 0, stab_viol = 0;

    // Master and memory agent: acts on the falling edge so every handshake is decided
    // half a cycle before the rising edge that completes it.
    initial begin
        m0_araddr = '0; m0_arvalid = 1'b0;
        m1_araddr = '0; m1_arvalid = 1'b0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m0_q.delete(); m1_q.delete(); mem_data_q.delete(); mem_resp_q.delete();
                m0_arvalid = 1'b0; m1_arvalid = 1'b0;
                s_arready = 1'b0; s_rvalid = 1'b0;
                r_pend = 0; ar_cnt = 0; r_cnt = 0;
                ar_fire = 0; r_fire = 0; m0_fire = 0; m1_fire = 0;
                seen_busy = 0; idle_run = 0; ar_hold = 0;
            end else begin
                if (r_fire) begin s_rvalid = 1'b0; r_pend = 0; end
                if (ar_fire) begin r_pend = 1; r_cnt = 0; ar_cnt = 0; s_arready = 1'b0; end
                if (m0_fire) m0_arvalid = 1'b0;
                if (m1_fire) m1_arvalid = 1'b0;
                if (!m0_arvalid && m0_q.size() > 0) begin
                    m0_araddr = m0_q.pop_front(); m0_arvalid = 1'b1; rise0 = cyc;
                end
                if (!m1_arvalid && m1_q.size() > 0) begin
                    m1_araddr = m1_q.pop_front(); m1_arvalid = 1'b1; rise1 = cyc;
                end
                #1;
                if (s_arvalid && !r_pend) begin
                    if (ar_cnt >= ar_wait) s_arready = 1'b1;
                    else begin s_arready = 1'b0; ar_cnt++; end
                end else begin
                    s_arready = 1'b0;
                end
                if (r_pend && !s_rvalid) begin
                    if (r_cnt >= r_wait) begin
                        s_rvalid = 1'b1;
                        s_rdata  = (mem_data_q.size() > 0) ? mem_data_q.pop_front() : 32'hA5A5_0000;
                        s_rresp  = (mem_resp_q.size() > 0) ? mem_resp_q.pop_front() : 2'b00;
                    end else begin
                        r_cnt++;
                    end
                end
                #1;
                ar_fire = s_arvalid && s_arready;
                r_fire  = s_rvalid && s_rready;
                m0_fire = m0_arvalid && m0_arready;
                m1_fire = m1_arvalid && m1_arready;
                if (ar_fire) lg_addr.push_back(s_araddr);
                if (m0_rvalid && m0_rready) begin
                    lg_m.push_back(0); lg_data.push_back(m0_rdata); lg_resp.push_back(m0_rresp);
                    lg_grant.push_back(int'(grant)); lg_lat.push_back(cyc + 1 - rise0);
                end
                if (m1_rvalid && m1_rready) begin
                    lg_m.push_back(1); lg_data.push_back(m1_rdata); lg_resp.push_back(m1_rresp);
                    lg_grant.push_back(int'(grant)); lg_lat.push_back(cyc + 1 - rise1);
                end
                if ((grant == 1'b0 && (m1_arready || m1_rvalid)) ||
                    (grant == 1'b1 && (m0_arready || m0_rvalid))) viol_ng++;
                if (m1_arready || m1_rvalid) m1_seen++;
                if ((m0_rvalid || m1_rvalid) && !s_rvalid) early_r++;
                if (ar_hold && (!s_arvalid || s_araddr !== ar_hold_addr)) stab_viol++;
                ar_hold = s_arvalid && !s_arready;
                ar_hold_addr = s_araddr;
                if (!busy) idle_run++;
                else begin
                    if (seen_busy && idle_run > 0) gap_q.push_back(idle_run);
                    idle_run = 0;
                    seen_busy = 1;
                end
            end
        end
    end

    task automatic clear_logs();
        lg_m.delete(); lg_data.delete(); lg_resp.delete();
        lg_grant.delete(); lg_lat.delete(); lg_addr.delete();
    endtask

    task automatic wait_log(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #2;
            if (lg_m.size() >= n) ok = 1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_rready = 1'b1; m1_rready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if ({m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready, busy} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready, busy});
        end
        vectors++;
        if (grant !== 1'b0) begin miscompares++; $display("FAIL reset_grant: got %b want 0", grant); end
        vectors++;
        if (s_araddr !== 32'h0) begin miscompares++; $display("FAIL reset_araddr: got %h want 0", s_araddr); end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_no_req_busy: got %b want 0", busy); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        clear_logs();
        mem_data_q.push_back(32'h1111_1111); mem_resp_q.push_back(2'b00);
        mem_data_q.push_back(32'h2222_2222); mem_resp_q.push_back(2'b00);
        m0_q.push_back(32'h8000_0004);
        m1_q.push_back(32'h8000_1000);
        wait_log(2, 30, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL simul_timeout: got %0d reads want 2", lg_m.size());
        end else begin
            vectors++;
            if (lg_grant[0] !== 0 || lg_grant[1] !== 1) begin
                miscompares++;
                $display("FAIL simul_grants: got %0d,%0d want 0,1", lg_grant[0], lg_grant[1]);
            end
            vectors++;
            if (lg_addr[0] !== 32'h8000_0004 || lg_addr[1] !== 32'h8000_1000) begin
                miscompares++;
                $display("FAIL simul_addr: got %h,%h want 80000004,80001000", lg_addr[0], lg_addr[1]);
            end
            vectors++;
            if (lg_m[1] !== 1 || lg_data[1] !== 32'h2222_2222) begin
                miscompares++;
                $display("FAIL simul_m1_data: got m%0d %h want m1 22222222", lg_m[1], lg_data[1]);
            end
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] exp_addr [4];
        clear_logs();
        gap_q.delete(); seen_busy = 0; viol_ng = 0;
        exp_addr[0] = 32'h0000_0100; exp_addr[1] = 32'h0000_0200;
        exp_addr[2] = 32'h0000_0104; exp_addr[3] = 32'h0000_0204;
        m0_q.push_back(32'h0000_0100); m0_q.push_back(32'h0000_0104);
        m1_q.push_back(32'h0000_0200); m1_q.push_back(32'h0000_0204);
        for (int i = 0; i < 4; i++) begin
            mem_data_q.push_back(32'hD000_0000 + i); mem_resp_q.push_back(2'b00);
        end
        wait_log(4, 60, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_timeout: got %0d reads want 4", lg_m.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (lg_grant[i] !== (i % 2) || lg_m[i] !== (i % 2) || lg_addr[i] !== exp_addr[i] ||
                    lg_data[i] !== 32'hD000_0000 + i) begin
                    miscompares++;
                    $display("FAIL b2b_txn%0d: got grant %0d m%0d addr %h data %h want grant %0d addr %h data %h",
                             i, lg_grant[i], lg_m[i], lg_addr[i], lg_data[i], i % 2, exp_addr[i],
                             32'hD000_0000 + i);
                end
            end
            vectors++;
            if (gap_q.size() !== 3) begin
                miscompares++;
                $display("FAIL b2b_gap_count: got %0d want 3", gap_q.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    vectors++;
                    if (gap_q[i] !== 1) begin
                        miscompares++;
                        $display("FAIL b2b_gap%0d: got %0d idle cycles want 1", i, gap_q[i]);
                    end
                end
            end
        end
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (viol_ng !== 0) begin miscompares++; $display("FAIL b2b_nongrant_quiet: got %0d want 0", viol_ng); end
    endtask

    task automatic test_single_m0();
        bit ok;
        clear_logs();
        m1_seen = 0; viol_ng = 0;
        mem_data_q.push_back(32'h0000_0413); mem_resp_q.push_back(2'b00);
        m0_q.push_back(32'h8000_0000);
        wait_log(1, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_timeout: got %0d reads want 1", lg_m.size());
        end else begin
            vectors++;
            if (lg_m[0] !== 0 || lg_data[0] !== 32'h0000_0413 || lg_resp[0] !== 2'b00) begin
                miscompares++;
                $display("FAIL single_data: got m%0d %h resp %b want m0 00000413 resp 00",
                         lg_m[0], lg_data[0], lg_resp[0]);
            end
            vectors++;
            if (lg_lat[0] !== 3) begin
                miscompares++;
                $display("FAIL single_latency: got %0d want 3", lg_lat[0]);
            end
            vectors++;
            if (lg_addr[0] !== 32'h8000_0000) begin
                miscompares++;
                $display("FAIL single_addr: got %h want 80000000", lg_addr[0]);
            end
        end
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (m1_seen !== 0) begin miscompares++; $display("FAIL single_m1_quiet: got %0d want 0", m1_seen); end
    endtask

    task automatic test_wait_states();
        bit ok;
        clear_logs();
        ar_wait = 3; r_wait = 5; stab_viol = 0; early_r = 0;
        mem_data_q.push_back(32'hDEAD_BEEF); mem_resp_q.push_back(2'b00);
        m0_q.push_back(32'h8000_0100);
        wait_log(1, 40, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL wait_timeout: got %0d reads want 1", lg_m.size());
        end else begin
            vectors++;
            if (lg_data[0] !== 32'hDEAD_BEEF || lg_m[0] !== 0) begin
                miscompares++;
                $display("FAIL wait_data: got m%0d %h want m0 deadbeef", lg_m[0], lg_data[0]);
            end
            vectors++;
            if (lg_lat[0] !== 11) begin
                miscompares++;
                $display("FAIL wait_latency: got %0d want 11", lg_lat[0]);
            end
        end
        repeat (5) @(posedge clk);
        #2;
        vectors++;
        if (stab_viol !== 0) begin miscompares++; $display("FAIL wait_ar_stable: got %0d want 0", stab_viol); end
        vectors++;
        if (early_r !== 0) begin miscompares++; $display("FAIL wait_r_early: got %0d want 0", early_r); end
        vectors++;
        if (lg_m.size() !== 1) begin miscompares++; $display("FAIL wait_once: got %0d want 1", lg_m.size()); end
        ar_wait = 0; r_wait = 0;
    endtask

    task automatic test_error_resp();
        bit ok;
        clear_logs();
        mem_data_q.push_back(32'hBAD0_BAD0); mem_resp_q.push_back(2'b10);
        m1_q.push_back(32'h8000_2000);
        wait_log(1, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL err_timeout: got %0d reads want 1", lg_m.size());
        end else begin
            vectors++;
            if (lg_m[0] !== 1 || lg_resp[0] !== 2'b10 || lg_data[0] !== 32'hBAD0_BAD0) begin
                miscompares++;
                $display("FAIL err_resp: got m%0d resp %b data %h want m1 resp 10 data bad0bad0",
                         lg_m[0], lg_resp[0], lg_data[0]);
            end
        end
        mem_data_q.push_back(32'h0000_0513); mem_resp_q.push_back(2'b00);
        m0_q.push_back(32'h8000_0008);
        wait_log(2, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL err_next_timeout: got %0d reads want 2", lg_m.size());
        end else begin
            vectors++;
            if (lg_m[1] !== 0 || lg_resp[1] !== 2'b00 || lg_data[1] !== 32'h0000_0513) begin
                miscompares++;
                $display("FAIL err_next: got m%0d resp %b data %h want m0 resp 00 data 00000513",
                         lg_m[1], lg_resp[1], lg_data[1]);
            end
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic test_reset_in_data();
        bit ok;
        bit reached;
        clear_logs();
        m1_rready = 1'b0;
        mem_data_q.push_back(32'hCAFE_F00D); mem_resp_q.push_back(2'b00);
        m1_q.push_back(32'h8000_0200);
        reached = 0;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(posedge clk); #2;
            if (s_rvalid && busy && grant) reached = 1;
        end
        vectors++;
        if (!reached) begin
            miscompares++;
            $display("FAIL rstdata_reach: got not in DATA want s_rvalid pending with grant 1");
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready, busy, grant} !== 8'b0) begin
            miscompares++;
            $display("FAIL rstdata_outputs: got %b want 00000000",
                     {m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_arvalid, s_rready, busy, grant});
        end
        vectors++;
        if (s_araddr !== 32'h0) begin miscompares++; $display("FAIL rstdata_araddr: got %h want 0", s_araddr); end
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if (lg_m.size() !== 0) begin
            miscompares++;
            $display("FAIL rstdata_ignored: got %0d reads want 0", lg_m.size());
        end
        rst = 1'b1;
        m1_rready = 1'b1;
        mem_data_q.push_back(32'h0000_ABCD); mem_resp_q.push_back(2'b00);
        m1_q.push_back(32'h8000_3000);
        wait_log(1, 20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rstdata_after_timeout: got %0d reads want 1", lg_m.size());
        end else begin
            vectors++;
            if (lg_m[0] !== 1 || lg_grant[0] !== 1 || lg_data[0] !== 32'h0000_ABCD ||
                lg_addr[lg_addr.size()-1] !== 32'h8000_3000) begin
                miscompares++;
                $display("FAIL rstdata_after: got m%0d grant %0d data %h addr %h want m1 grant 1 data 0000abcd addr 80003000",
                         lg_m[0], lg_grant[0], lg_data[0], lg_addr[lg_addr.size()-1]);
            end
        end
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        m0_rready = 1'b1;
        m1_rready = 1'b1;
        test_reset();
        test_simultaneous();
        test_back_to_back();
        test_single_m0();
        test_wait_states();
        test_error_resp();
        test_reset_in_data();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the address and read-data width.
REQ-002 The block SHALL have the following port list, in this order, with clock and reset first:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_araddr  in  WIDTH  fetch-unit read address.
- m0_arvalid  in  1  fetch-unit address valid.
- m0_arready  out  1  address accepted.
- m0_rdata  out  WIDTH  read data.
- m0_rresp  out  2  read response.
- m0_rvalid  out  1  read data valid.
- m0_rready  in  1  fetch-unit data ready.
- m1_araddr, m1_arvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_rready  --  load-unit ports; same widths and directions as the m0_* ports.
- s_araddr  out  WIDTH  address to memory.
- s_arvalid  out  1  address valid to memory.
- s_arready  in  1  memory accepts address.
- s_rdata  in  WIDTH  memory read data.
- s_rresp  in  2  memory response.
- s_rvalid  in  1  memory data valid.
- s_rready  out  1  ready toward memory.
- busy  out  1  a transaction is in progress (state is not IDLE).
- grant  out  1  index of the current or last granted master.

Function
REQ-003 The arbiter SHALL allow at most one outstanding read; no second address is issued before the current R handshake completes.
REQ-004 The state machine SHALL have the states IDLE, ADDR and DATA, held in a registered state variable.
REQ-005 In IDLE, when at least one mN_arvalid is 1, the arbiter SHALL register the winner in grant and move to ADDR on the next edge.
- Arbitration costs exactly 1 cycle; no address is forwarded while in IDLE.
REQ-006 Arbitration SHALL be round-robin between the two masters.
- When both request, the master not granted last wins.
- When only one requests, that master wins.
REQ-007 In ADDR, s_araddr and s_arvalid SHALL be driven combinationally from the granted master, and that master's mN_arready SHALL equal s_arready.
REQ-008 In ADDR, the arbiter SHALL move to DATA on the edge where s_arvalid && s_arready.
REQ-009 In DATA, s_rdata and s_rresp SHALL be routed to both mN_rdata/mN_rresp ports; s_rvalid SHALL go only to the granted mN_rvalid; s_rready SHALL equal the granted mN_rready.
REQ-010 In DATA, the arbiter SHALL return to IDLE on s_rvalid && s_rready and update last-grant to the served master.
- A new request present in that same cycle is arbitrated in IDLE on the following cycle.
REQ-011 The non-granted master SHALL see arready=0 and rvalid=0 at all times.
- The granted master SHALL see arready=0 outside ADDR and rvalid=0 outside DATA.
REQ-012 In IDLE, s_arvalid and s_rready SHALL be 0 and s_araddr SHALL be 0.
REQ-013 The s_rresp value SHALL be passed through unmodified, including SLVERR and DECERR; an error response ends the transaction normally.
REQ-014 If the granted master drops arvalid in ADDR (a protocol violation), the arbiter SHALL stay in ADDR and forward s_arvalid=0; it SHALL NOT regrant.
REQ-015 A request arriving while busy SHALL be held by its master and served after the current transaction, per REQ-006.
REQ-016 Minimum latency SHALL be 3 cycles from arvalid rising to the data handshake, with zero-wait memory.
- 1 cycle arbitration, 1 cycle address, 1 cycle data.

Reset
REQ-017 Asserting rst (low) SHALL immediately force the following, regardless of state, including mid-transaction:
- state = IDLE;
- grant = 0;
- last-grant = 1, so m0 wins the first tie;
- every *_arready, *_rvalid, s_arvalid and s_rready = 0;
- s_araddr = 0.
REQ-018 A response returned by memory after a mid-transaction reset SHALL be ignored (s_rready is 0); the memory model is re-reset together with the arbiter.
REQ-019 Deassertion of rst SHALL take effect at the first rising clk edge after release; no request is granted in that same cycle.

Structure
REQ-020 The state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2) and the master indices (M_IFU=0, M_LSU=1) SHALL live in the shared package arb_pkg.
REQ-021 The round-robin decision SHALL be a sub-module rr_arb2 with inputs req[1:0] and last, and output gnt.
- rr_arb2 is purely combinational; all registers stay in axi_rd_arbiter.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Single m0 read: m0 araddr=0x80000000, memory returns 0x00000413 with resp 0, zero wait -> m0_rvalid=1 exactly 3 cycles after m0_arvalid; m1 sees nothing.
- Simultaneous requests after reset: m0=0x80000004, m1=0x80001000 -> m0 served first; m1 served next with its address on s_araddr; grant sequence 0 then 1.
- Back-to-back contention: both hold requests for 4 transactions -> grants alternate 0,1,0,1; busy=0 for exactly 1 cycle between transactions.
- Slave wait states: s_arready delayed 3 cycles and s_rvalid delayed 5 cycles -> s_araddr/s_arvalid held stable and no R routed early; data 0xDEADBEEF delivered once.
- Error response: s_rresp=2'b10 on an m1 read -> m1_rresp=2'b10, transaction completes, next request served normally.
- Reset in DATA: assert rst with s_rvalid pending -> all outputs 0 the same cycle; after release, an m1-only request is granted with grant=1.
